psf_dmem_mo: RTL

PSF_DMEM_MO -- requirements
Module: psf_dmem_mo

---
 rtl/psf_dmem_mo.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/psf_dmem_mo.sv
// Data-memory port: local scratchpad/cache-control, rest to AXI4 single beats.
// Ports: mem_* request/response, aw/w/b/ar/r AXI4 master, clk_i, rst_i (sync high).
module psf_dmem_mo #(
  parameter int         SPAD_AW    = 10,
  parameter int         REQ_DEPTH  = 4,
  parameter int         REQ_ADDR_W = 2,
  parameter int         MAX_OUT    = 4,
  parameter int         OUT_W      = 3,
  parameter int         POSTED_WR  = 1,
  parameter logic [3:0] AXI_ID     = 4'd8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_wr_i,
  input  logic        mem_rd_i,
  input  logic [3:0]  mem_wr_i,
  input  logic [10:0] mem_req_tag_i,
  output logic [31:0] mem_data_rd_o,
  output logic        mem_accept_o,
  output logic        mem_ack_o,
  output logic        mem_error_o,
  output logic [10:0] mem_resp_tag_o,
  output logic        awvalid,
  output logic [31:0] awaddr,
  output logic [3:0]  awid,
  output logic [7:0]  awlen,
  output logic [1:0]  awburst,
  output logic [2:0]  awsize,
  input  logic        awready,
  output logic        wvalid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  input  logic        wready,
  input  logic        bvalid,
  input  logic [1:0]  bresp,
  input  logic [3:0]  bid,
  output logic        bready,
  output logic        arvalid,
  output logic [31:0] araddr,
  output logic [3:0]  arid,
  output logic [7:0]  arlen,
  output logic [1:0]  arburst,
  output logic [2:0]  arsize,
  input  logic        arready,
  input  logic        rvalid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic [3:0]  rid,
  input  logic        rlast,
  output logic        rready
);

  localparam int FW = REQ_ADDR_W + 1;
  localparam int TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int WORDS = 2 ** (SPAD_AW - 2);

  logic [31:0] ram [WORDS];
  logic [31:0] cc_q;

  // request FIFO
  logic [31:0] q_addr [REQ_DEPTH];
  logic [31:0] q_data [REQ_DEPTH];
  logic [3:0]  q_wr   [REQ_DEPTH];
  logic        q_rd   [REQ_DEPTH];
  logic        q_post [REQ_DEPTH];
  logic [10:0] q_tag  [REQ_DEPTH];
  logic [REQ_ADDR_W-1:0] wptr, rptr;
  logic [FW-1:0] fcnt;

  // in-order tracking FIFO
  logic [10:0]   t_tag  [MAX_OUT];
  logic          t_post [MAX_OUT];
  logic [TW-1:0] tw, tr;

  logic [OUT_W-1:0] cnt;
  logic out_rd, aw_done, w_done;
  logic ack_q;
  logic [31:0] ack_data_q;
  logic [10:0] ack_tag_q;

  logic is_spad, is_io, is_cc, is_local, has_req, is_wr;
  logic fifo_empty, fifo_full, local_ok, loc_fire, push, posted;
  logic h_rd, can_issue, aw_fire, w_fire, ar_fire, wr_issue, issue;
  logic r_fire, b_fire, resp;
  logic unused_ok;

  assign is_spad = ({1'b0, mem_addr_i[30:SPAD_AW], {SPAD_AW{1'b0}}}
                    == 32'h1F80_0000);
  assign is_io   = ({1'b0, mem_addr_i[30:12], 12'b0} == 32'h1F80_1000);
  assign is_cc   = (mem_addr_i == 32'hFFFE_0130);
  assign is_local = is_spad | is_cc;
  assign has_req  = mem_rd_i | (|mem_wr_i);
  assign is_wr    = (|mem_wr_i) & ~mem_rd_i;

  assign fifo_empty = (fcnt == '0);
  assign fifo_full  = (fcnt == FW'(REQ_DEPTH));
  // Local accesses bypass the AXI path, so they wait for it to drain
  // to keep responses in order.
  assign local_ok   = fifo_empty & (cnt == '0) & ~ack_q;

  assign mem_accept_o = ~rst_i & (is_local ? local_ok : ~fifo_full);
  assign loc_fire = has_req & is_local & mem_accept_o;
  assign push     = has_req & ~is_local & mem_accept_o;
  assign posted   = (POSTED_WR != 0) & is_wr & ~is_io;

  // issue: never mix reads and writes in flight
  assign h_rd = q_rd[rptr];
  assign can_issue = ~fifo_empty & (cnt < OUT_W'(MAX_OUT)) &
                     ((cnt == '0) | (h_rd == out_rd));

  assign awvalid = ~rst_i & can_issue & ~h_rd & ~aw_done;
  assign wvalid  = ~rst_i & can_issue & ~h_rd & ~w_done;
  assign arvalid = ~rst_i & can_issue & h_rd;

  assign aw_fire  = awvalid & awready;
  assign w_fire   = wvalid & wready;
  assign ar_fire  = arvalid & arready;
  assign wr_issue = can_issue & ~h_rd & ~rst_i &
                    (aw_done | aw_fire) & (w_done | w_fire);
  assign issue    = wr_issue | ar_fire;

  assign awaddr  = q_addr[rptr];
  assign awid    = AXI_ID;
  assign awlen   = 8'd0;
  assign awburst = 2'b01;
  assign awsize  = 3'd2;
  assign wdata   = q_data[rptr];
  assign wstrb   = q_wr[rptr];
  assign wlast   = 1'b1;
  assign araddr  = q_addr[rptr];
  assign arid    = AXI_ID;
  assign arlen   = 8'd0;
  assign arburst = 2'b01;
  assign arsize  = q_tag[rptr][0] ? 3'd0 :
                   q_tag[rptr][1] ? 3'd1 : 3'd2;

  // stall AXI responses while a local ack occupies the response port
  assign rready = ~rst_i & ~ack_q;
  assign bready = rready;
  assign r_fire = rvalid & rready & (cnt != '0);
  assign b_fire = bvalid & bready & (cnt != '0);
  assign resp   = r_fire | b_fire;

  assign mem_ack_o = ~rst_i &
    (ack_q | r_fire | (b_fire & ~t_post[tr]));
  assign mem_error_o = ~rst_i &
    ((r_fire & (rresp != 2'b00)) |
     (b_fire & ~t_post[tr] & (bresp != 2'b00)));
  assign mem_data_rd_o  = r_fire ? rdata : ack_data_q;
  assign mem_resp_tag_o = resp ? t_tag[tr] : ack_tag_q;

  assign unused_ok = ^{bid, rid, rlast};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr    <= '0;
      rptr    <= '0;
      fcnt    <= '0;
      tw      <= '0;
      tr      <= '0;
      cnt     <= '0;
      out_rd  <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      ack_q   <= 1'b0;
      cc_q    <= '0;
    end else begin
      ack_q <= loc_fire | (push & posted);
      if (loc_fire & is_cc & is_wr) cc_q <= mem_data_wr_i;
      if (push)
        wptr <= (wptr == REQ_ADDR_W'(REQ_DEPTH - 1)) ? '0 : wptr + 1'b1;
      if (issue)
        rptr <= (rptr == REQ_ADDR_W'(REQ_DEPTH - 1)) ? '0 : rptr + 1'b1;
      fcnt <= fcnt + FW'(push) - FW'(issue);
      if (issue) begin
        tw     <= (tw == TW'(MAX_OUT - 1)) ? '0 : tw + 1'b1;
        out_rd <= h_rd;
      end
      if (resp)
        tr <= (tr == TW'(MAX_OUT - 1)) ? '0 : tr + 1'b1;
      cnt <= cnt + OUT_W'(issue) - OUT_W'(resp);
      if (wr_issue) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_fire) aw_done <= 1'b1;
        if (w_fire)  w_done  <= 1'b1;
      end
    end
  end

  // storage without reset: scratchpad, FIFO payloads, ack payload
  always_ff @(posedge clk_i) begin
    if (loc_fire & is_spad & is_wr) begin
      for (int b = 0; b < 4; b++)
        if (mem_wr_i[b])
          ram[mem_addr_i[SPAD_AW-1:2]][b*8 +: 8] <= mem_data_wr_i[b*8 +: 8];
    end
    if (push) begin
      q_addr[wptr] <= mem_addr_i;
      q_data[wptr] <= mem_data_wr_i;
      q_wr[wptr]   <= mem_rd_i ? 4'b0 : mem_wr_i;
      q_rd[wptr]   <= mem_rd_i;
      q_post[wptr] <= posted;
      q_tag[wptr]  <= mem_req_tag_i;
    end
    if (issue) begin
      t_tag[tw]  <= q_tag[rptr];
      t_post[tw] <= q_post[rptr];
    end
    ack_tag_q  <= mem_req_tag_i;
    ack_data_q <= ~loc_fire ? 32'd0 :
                  is_cc ? cc_q : ram[mem_addr_i[SPAD_AW-1:2]];
  end

endmodule
